// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Holds the state encoding, the event priority encoder and register constants.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_HALTED   = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE     = 3'd0,
        EV_MEMSTALL = 3'd1,
        EV_HALT     = 3'd2,
        EV_REDIR    = 3'd3,
        EV_LU       = 3'd4
    } event_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Highest-priority event wins; later ones are masked for this cycle.
    function automatic event_t prio_event(
        input logic memstall,
        input logic halt,
        input logic redir,
        input logic lu
    );
        if (memstall)   return EV_MEMSTALL;
        else if (halt)  return EV_HALT;
        else if (redir) return EV_REDIR;
        else if (lu)    return EV_LU;
        else            return EV_NONE;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX feeding a source register of ID.
// Purely combinational so the forwarding unit can share it.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       is_load_i,
    input  logic       rf_we_i,
    input  logic [4:0] wa_i,
    input  logic [4:0] ra1_i,
    input  logic [4:0] ra2_i,
    input  logic       use_ra1_i,
    input  logic       use_ra2_i,
    output logic       lu_o
);

    logic hit1;
    logic hit2;

    assign hit1 = use_ra1_i && (ra1_i == wa_i);
    assign hit2 = use_ra2_i && (ra2_i == wa_i);
    assign lu_o = is_load_i && rf_we_i && (wa_i != REG_ZERO) && (hit1 || hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline.
// Handles load-use, MEM-stage redirects, memory waits and HALT draining.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             isLoad_IDEX,
    input  logic             RF_WE_IDEX,
    input  logic [4:0]       WA_IDEX,
    input  logic [4:0]       RA1_IFID,
    input  logic [4:0]       RA2_IFID,
    input  logic             USE_RA1_IFID,
    input  logic             USE_RA2_IFID,
    input  logic             isJump_EXMEM,
    input  logic             Branch_Cond_EXMEM,
    input  logic             MemAccess_EXMEM,
    input  logic             D_MEM_RDY,
    input  logic             HALT_EXMEM,
    output logic             PC_WE,
    output logic             IFID_WE,
    output logic             IFID_FLUSH,
    output logic             IDEX_WE,
    output logic             IDEX_FLUSH,
    output logic             EXMEM_WE,
    output logic             EXMEM_FLUSH,
    output logic             MEMWB_FLUSH,
    output logic             REDIRECT,
    output logic             HALTED,
    output logic             MEM_TO_ERR,
    output logic [2:0]       STATE,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_q, flush_d;
    logic               stall_inc;
    logic               flush_inc;
    logic               memstall;
    logic               redir;
    logic               lu;
    event_t             ev;

    assign memstall = MemAccess_EXMEM && !D_MEM_RDY;
    assign redir    = isJump_EXMEM || Branch_Cond_EXMEM;

    hazard_detect u_hazard_detect (
        .is_load_i (isLoad_IDEX),
        .rf_we_i   (RF_WE_IDEX),
        .wa_i      (WA_IDEX),
        .ra1_i     (RA1_IFID),
        .ra2_i     (RA2_IFID),
        .use_ra1_i (USE_RA1_IFID),
        .use_ra2_i (USE_RA2_IFID),
        .lu_o      (lu)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        drain_d     = drain_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        ev          = EV_NONE;
        PC_WE       = 1'b1;
        IFID_WE     = 1'b1;
        IDEX_WE     = 1'b1;
        EXMEM_WE    = 1'b1;
        IFID_FLUSH  = 1'b0;
        IDEX_FLUSH  = 1'b0;
        EXMEM_FLUSH = 1'b0;
        MEMWB_FLUSH = 1'b0;
        REDIRECT    = 1'b0;
        unique case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                ev      = prio_event(memstall, HALT_EXMEM, redir, lu);
                state_d = ST_RUN;
                wait_d  = '0;
                unique case (ev)
                    EV_MEMSTALL: begin
                        PC_WE       = 1'b0;
                        IFID_WE     = 1'b0;
                        IDEX_WE     = 1'b0;
                        EXMEM_WE    = 1'b0;
                        MEMWB_FLUSH = 1'b1;
                        stall_inc   = 1'b1;
                        wait_d      = wait_q + 1'b1;
                        if (wait_q == WAIT_W'(MEM_TIMEOUT - 1))
                            state_d = ST_ERROR;
                        else
                            state_d = ST_MEM_WAIT;
                    end
                    EV_HALT: begin
                        PC_WE       = 1'b0;
                        IFID_FLUSH  = 1'b1;
                        IDEX_FLUSH  = 1'b1;
                        EXMEM_FLUSH = 1'b1;
                        state_d     = ST_DRAIN;
                        drain_d     = DRN_W'(DRAIN_CYCLES - 1);
                    end
                    EV_REDIR: begin
                        REDIRECT    = 1'b1;
                        IFID_FLUSH  = 1'b1;
                        IDEX_FLUSH  = 1'b1;
                        EXMEM_FLUSH = 1'b1;
                        flush_inc   = 1'b1;
                    end
                    EV_LU: begin
                        PC_WE      = 1'b0;
                        IFID_WE    = 1'b0;
                        IDEX_FLUSH = 1'b1;
                        stall_inc  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_DRAIN: begin
                PC_WE       = 1'b0;
                IFID_FLUSH  = 1'b1;
                IDEX_FLUSH  = 1'b1;
                EXMEM_FLUSH = 1'b1;
                if (drain_q == '0)
                    state_d = ST_HALTED;
                else
                    drain_d = drain_q - 1'b1;
            end
            ST_HALTED, ST_ERROR: begin
                PC_WE       = 1'b0;
                IFID_WE     = 1'b0;
                IDEX_WE     = 1'b0;
                EXMEM_WE    = 1'b0;
                MEMWB_FLUSH = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
        // Hold the pipeline in a benign pass-through while reset is applied.
        if (!RSTn) begin
            PC_WE       = 1'b1;
            IFID_WE     = 1'b1;
            IDEX_WE     = 1'b1;
            EXMEM_WE    = 1'b1;
            IFID_FLUSH  = 1'b0;
            IDEX_FLUSH  = 1'b0;
            EXMEM_FLUSH = 1'b0;
            MEMWB_FLUSH = 1'b0;
            REDIRECT    = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && (stall_q != '1))
            stall_d = stall_q + 1'b1;
        if (flush_inc && (flush_q != '1))
            flush_d = flush_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            drain_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign STATE      = state_q;
    assign HALTED     = (state_q == ST_HALTED);
    assign MEM_TO_ERR = (state_q == ST_ERROR);
    assign STALL_CNT  = stall_q;
    assign FLUSH_CNT  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl.
// Inputs change at negedge; outputs are sampled 1ns later.
module tb_pipe_hazard_ctrl;

    logic        CLK;
    logic        RSTn;
    logic        isLoad_IDEX;
    logic        RF_WE_IDEX;
    logic [4:0]  WA_IDEX;
    logic [4:0]  RA1_IFID;
    logic [4:0]  RA2_IFID;
    logic        USE_RA1_IFID;
    logic        USE_RA2_IFID;
    logic        isJump_EXMEM;
    logic        Branch_Cond_EXMEM;
    logic        MemAccess_EXMEM;
    logic        D_MEM_RDY;
    logic        HALT_EXMEM;
    logic        PC_WE;
    logic        IFID_WE;
    logic        IFID_FLUSH;
    logic        IDEX_WE;
    logic        IDEX_FLUSH;
    logic        EXMEM_WE;
    logic        EXMEM_FLUSH;
    logic        MEMWB_FLUSH;
    logic        REDIRECT;
    logic        HALTED;
    logic        MEM_TO_ERR;
    logic [2:0]  STATE;
    logic [31:0] STALL_CNT;
    logic [31:0] FLUSH_CNT;

    int nvec;
    int nerr;
    int exp_stall;
    int exp_flush;

    // {PC_WE,IFID_WE,IFID_FLUSH,IDEX_WE,IDEX_FLUSH,EXMEM_WE,EXMEM_FLUSH,MEMWB_FLUSH,REDIRECT}
    localparam logic [8:0] C_NORM  = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] C_LU    = 9'b0_0_0_1_1_1_0_0_0;
    localparam logic [8:0] C_REDIR = 9'b1_1_1_1_1_1_1_0_1;
    localparam logic [8:0] C_STALL = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] C_HALT  = 9'b0_1_1_1_1_1_1_0_0;

    logic [8:0] ctl;
    assign ctl = {PC_WE, IFID_WE, IFID_FLUSH, IDEX_WE, IDEX_FLUSH,
                  EXMEM_WE, EXMEM_FLUSH, MEMWB_FLUSH, REDIRECT};

    pipe_hazard_ctrl #(
        .DRAIN_CYCLES (2),
        .MEM_TIMEOUT  (15),
        .CNT_W        (32)
    ) dut (
        .CLK               (CLK),
        .RSTn              (RSTn),
        .isLoad_IDEX       (isLoad_IDEX),
        .RF_WE_IDEX        (RF_WE_IDEX),
        .WA_IDEX           (WA_IDEX),
        .RA1_IFID          (RA1_IFID),
        .RA2_IFID          (RA2_IFID),
        .USE_RA1_IFID      (USE_RA1_IFID),
        .USE_RA2_IFID      (USE_RA2_IFID),
        .isJump_EXMEM      (isJump_EXMEM),
        .Branch_Cond_EXMEM (Branch_Cond_EXMEM),
        .MemAccess_EXMEM   (MemAccess_EXMEM),
        .D_MEM_RDY         (D_MEM_RDY),
        .HALT_EXMEM        (HALT_EXMEM),
        .PC_WE             (PC_WE),
        .IFID_WE           (IFID_WE),
        .IFID_FLUSH        (IFID_FLUSH),
        .IDEX_WE           (IDEX_WE),
        .IDEX_FLUSH        (IDEX_FLUSH),
        .EXMEM_WE          (EXMEM_WE),
        .EXMEM_FLUSH       (EXMEM_FLUSH),
        .MEMWB_FLUSH       (MEMWB_FLUSH),
        .REDIRECT          (REDIRECT),
        .HALTED            (HALTED),
        .MEM_TO_ERR        (MEM_TO_ERR),
        .STATE             (STATE),
        .STALL_CNT         (STALL_CNT),
        .FLUSH_CNT         (FLUSH_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle();
        isLoad_IDEX       = 1'b0;
        RF_WE_IDEX        = 1'b0;
        WA_IDEX           = 5'd0;
        RA1_IFID          = 5'd0;
        RA2_IFID          = 5'd0;
        USE_RA1_IFID      = 1'b0;
        USE_RA2_IFID      = 1'b0;
        isJump_EXMEM      = 1'b0;
        Branch_Cond_EXMEM = 1'b0;
        MemAccess_EXMEM   = 1'b0;
        D_MEM_RDY         = 1'b1;
        HALT_EXMEM        = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] wa);
        isLoad_IDEX  = 1'b1;
        RF_WE_IDEX   = 1'b1;
        WA_IDEX      = wa;
        RA1_IFID     = 5'd3;
        RA2_IFID     = wa;
        USE_RA1_IFID = 1'b1;
        USE_RA2_IFID = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        RSTn = 1'b0;
        MemAccess_EXMEM = 1'b1;
        D_MEM_RDY       = 1'b0;
        HALT_EXMEM      = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        nvec++;
        if (ctl !== C_NORM) begin
            nerr++;
            $display("FAIL reset_ctl got=%b want=%b", ctl, C_NORM);
        end
        nvec++;
        if (STATE !== 3'd0 || HALTED !== 1'b0 || MEM_TO_ERR !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state got=%0d/%b/%b want=0/0/0", STATE, HALTED, MEM_TO_ERR);
        end
        nvec++;
        if (STALL_CNT !== 32'd0 || FLUSH_CNT !== 32'd0) begin
            nerr++;
            $display("FAIL reset_cnt got=%0d/%0d want=0/0", STALL_CNT, FLUSH_CNT);
        end
        idle();
        RSTn = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        @(negedge CLK);
        #1;
        nvec++;
        if (ctl !== C_NORM || STATE !== 3'd0) begin
            nerr++;
            $display("FAIL idle_run got=%b/%0d want=%b/0", ctl, STATE, C_NORM);
        end
    endtask

    task automatic test_load_use();
        @(negedge CLK);
        idle();
        set_lu(5'd5);
        USE_RA1_IFID = 1'b0;
        #1;
        nvec++;
        if (ctl !== C_LU) begin
            nerr++;
            $display("FAIL lu_ctl got=%b want=%b", ctl, C_LU);
        end
        exp_stall++;
        @(negedge CLK);
        idle();
        #1;
        nvec++;
        if (ctl !== C_NORM || STALL_CNT !== 32'(exp_stall)) begin
            nerr++;
            $display("FAIL lu_after got=%b/%0d want=%b/%0d", ctl, STALL_CNT, C_NORM, exp_stall);
        end
        set_lu(5'd0);
        #1;
        nvec++;
        if (ctl !== C_NORM) begin
            nerr++;
            $display("FAIL lu_x0 got=%b want=%b", ctl, C_NORM);
        end
        set_lu(5'd7);
        RA2_IFID     = 5'd9;
        RA1_IFID     = 5'd7;
        USE_RA1_IFID = 1'b0;
        #1;
        nvec++;
        if (ctl !== C_NORM) begin
            nerr++;
            $display("FAIL lu_unused got=%b want=%b", ctl, C_NORM);
        end
        USE_RA1_IFID = 1'b1;
        #1;
        nvec++;
        if (ctl !== C_LU) begin
            nerr++;
            $display("FAIL lu_ra1 got=%b want=%b", ctl, C_LU);
        end
        exp_stall++;
        @(negedge CLK);
        idle();
        #1;
        nvec++;
        if (STALL_CNT !== 32'(exp_stall)) begin
            nerr++;
            $display("FAIL lu_cnt got=%0d want=%0d", STALL_CNT, exp_stall);
        end
    endtask

    task automatic test_redirect();
        @(negedge CLK);
        idle();
        set_lu(5'd5);
        Branch_Cond_EXMEM = 1'b1;
        #1;
        nvec++;
        if (ctl !== C_REDIR) begin
            nerr++;
            $display("FAIL redir_ctl got=%b want=%b", ctl, C_REDIR);
        end
        exp_flush++;
        @(negedge CLK);
        idle();
        #1;
        nvec++;
        if (FLUSH_CNT !== 32'(exp_flush) || STALL_CNT !== 32'(exp_stall)) begin
            nerr++;
            $display("FAIL redir_cnt got=%0d/%0d want=%0d/%0d",
                     FLUSH_CNT, STALL_CNT, exp_flush, exp_stall);
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            idle();
            MemAccess_EXMEM = 1'b1;
            D_MEM_RDY       = 1'b0;
            isJump_EXMEM    = 1'b1;
            #1;
            nvec++;
            if (ctl !== C_STALL || STATE !== ((i == 0) ? 3'd0 : 3'd1)) begin
                nerr++;
                $display("FAIL memwait_c%0d got=%b/%0d want=%b", i, ctl, STATE, C_STALL);
            end
            exp_stall++;
        end
        @(negedge CLK);
        D_MEM_RDY = 1'b1;
        #1;
        nvec++;
        if (ctl !== C_REDIR || STATE !== 3'd1) begin
            nerr++;
            $display("FAIL memwait_rdy got=%b/%0d want=%b/1", ctl, STATE, C_REDIR);
        end
        exp_flush++;
        @(negedge CLK);
        idle();
        #1;
        nvec++;
        if (STATE !== 3'd0 || STALL_CNT !== 32'(exp_stall) || FLUSH_CNT !== 32'(exp_flush)) begin
            nerr++;
            $display("FAIL memwait_end got=%0d/%0d/%0d want=0/%0d/%0d",
                     STATE, STALL_CNT, FLUSH_CNT, exp_stall, exp_flush);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            idle();
            MemAccess_EXMEM = 1'b1;
            D_MEM_RDY       = 1'b0;
            #1;
            nvec++;
            if (ctl !== C_STALL) begin
                nerr++;
                $display("FAIL to_stall%0d got=%b want=%b", i, ctl, C_STALL);
            end
            if (i == 14) begin
                nvec++;
                if (STATE !== 3'd1 || MEM_TO_ERR !== 1'b0) begin
                    nerr++;
                    $display("FAIL to_pre got=%0d/%b want=1/0", STATE, MEM_TO_ERR);
                end
            end
            exp_stall++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (i > 0) idle();
            #1;
            nvec++;
            if (STATE !== 3'd4 || MEM_TO_ERR !== 1'b1 || ctl !== C_STALL) begin
                nerr++;
                $display("FAIL to_err%0d got=%0d/%b/%b want=4/1/%b",
                         i, STATE, MEM_TO_ERR, ctl, C_STALL);
            end
        end
        nvec++;
        if (STALL_CNT !== 32'(exp_stall)) begin
            nerr++;
            $display("FAIL to_cnt got=%0d want=%0d", STALL_CNT, exp_stall);
        end
        @(negedge CLK);
        RSTn = 1'b0;
        #1;
        nvec++;
        if (STATE !== 3'd0 || MEM_TO_ERR !== 1'b0 || STALL_CNT !== 32'd0) begin
            nerr++;
            $display("FAIL to_reset got=%0d/%b/%0d want=0/0/0", STATE, MEM_TO_ERR, STALL_CNT);
        end
        exp_stall = 0;
        exp_flush = 0;
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    task automatic test_halt();
        @(negedge CLK);
        idle();
        HALT_EXMEM   = 1'b1;
        isJump_EXMEM = 1'b1;
        #1;
        nvec++;
        if (ctl !== C_HALT || STATE !== 3'd0) begin
            nerr++;
            $display("FAIL halt_ctl got=%b/%0d want=%b/0", ctl, STATE, C_HALT);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            idle();
            isJump_EXMEM = 1'b1;
            #1;
            nvec++;
            if (ctl !== C_HALT || STATE !== 3'd2 || HALTED !== 1'b0) begin
                nerr++;
                $display("FAIL drain%0d got=%b/%0d/%b want=%b/2/0", i, ctl, STATE, HALTED, C_HALT);
            end
        end
        @(negedge CLK);
        #1;
        nvec++;
        if (ctl !== C_STALL || STATE !== 3'd3 || HALTED !== 1'b1) begin
            nerr++;
            $display("FAIL halted got=%b/%0d/%b want=%b/3/1", ctl, STATE, HALTED, C_STALL);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            isJump_EXMEM = i[0];
            set_lu(5'(i % 7 + 1));
            #1;
            nvec++;
            if (PC_WE !== 1'b0 || HALTED !== 1'b1) begin
                nerr++;
                $display("FAIL halted_hold%0d got=%b/%b want=0/1", i, PC_WE, HALTED);
            end
        end
        nvec++;
        if (FLUSH_CNT !== 32'(exp_flush) || STALL_CNT !== 32'(exp_stall)) begin
            nerr++;
            $display("FAIL halt_cnt got=%0d/%0d want=%0d/%0d",
                     FLUSH_CNT, STALL_CNT, exp_flush, exp_stall);
        end
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        idle();
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        set_lu(5'd4);
        @(negedge CLK);
        idle();
        Branch_Cond_EXMEM = 1'b1;
        @(negedge CLK);
        idle();
        HALT_EXMEM = 1'b1;
        @(negedge CLK);
        idle();
        #1;
        nvec++;
        if (STATE !== 3'd2 || STALL_CNT !== 32'd1 || FLUSH_CNT !== 32'd1) begin
            nerr++;
            $display("FAIL ar_pre got=%0d/%0d/%0d want=2/1/1", STATE, STALL_CNT, FLUSH_CNT);
        end
        #1;
        RSTn = 1'b0;
        #1;
        nvec++;
        if (STATE !== 3'd0 || HALTED !== 1'b0 || STALL_CNT !== 32'd0 ||
            FLUSH_CNT !== 32'd0 || ctl !== C_NORM) begin
            nerr++;
            $display("FAIL ar_mid got=%0d/%b/%0d/%0d/%b want=0/0/0/0/%b",
                     STATE, HALTED, STALL_CNT, FLUSH_CNT, ctl, C_NORM);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        #1;
        nvec++;
        if (STATE !== 3'd0 || ctl !== C_NORM) begin
            nerr++;
            $display("FAIL ar_run got=%0d/%b want=0/%b", STATE, ctl, C_NORM);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        exp_stall = 0;
        exp_flush = 0;
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
